jtag_host: RTL and testbench

- JTAG master for the board/test side of the TAP interface: it drives TCK, TMS, TDI and TRST_b, and samples TDO.
- It runs from one system clock and accepts one command at a time: TAP reset, IR scan, DR scan, or idle clocks.
- Every command starts and ends in Run-Test/Idle.
- Used by the on-chip test sequencer and by benches to exercise the chip's TAP controller, IR and data-register chains.

---
 rtl/jtag_host_pkg.sv | 55 +++++
 rtl/jtag_host_tck_gen.sv | 44 ++++
 rtl/jtag_host.sv | 217 +++++++++++++++++++++
 tb/tb_jtag_host.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG host: op codes, controller states and the
// fixed TMS walks used to move the target TAP between Run-Test/Idle and the
// shift states. Every pattern is issued LSB first.
package jtag_host_pkg;

    localparam logic [1:0] OP_TAP_RESET = 2'b00;
    localparam logic [1:0] OP_SCAN_IR   = 2'b01;
    localparam logic [1:0] OP_SCAN_DR   = 2'b10;
    localparam logic [1:0] OP_RUN_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRST  = 3'd1,
        ST_HDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TRL   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] HDR_DR      = 3'b001;
    localparam int         HDR_DR_LEN  = 3;
    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] HDR_IR      = 4'b0011;
    localparam int         HDR_IR_LEN  = 4;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [1:0] TRL         = 2'b01;
    localparam int         TRL_LEN     = 2;
    // Five TMS=1 clocks reach Test-Logic-Reset from anywhere, then one into Idle
    localparam logic [5:0] RST_SEQ     = 6'b011111;
    localparam int         RST_SEQ_LEN = 6;

    // TMS bit for position idx of the lead-in walk belonging to op
    function automatic logic hdr_bit(input logic [1:0] op, input logic [2:0] idx);
        logic [7:0] pat;
        case (op)
            OP_SCAN_IR: pat = {4'b0000, HDR_IR};
            OP_SCAN_DR: pat = {5'b00000, HDR_DR};
            default:    pat = {2'b00, RST_SEQ};
        endcase
        return pat[idx];
    endfunction

    // Index of the last bit of the lead-in walk belonging to op
    function automatic logic [2:0] hdr_last(input logic [1:0] op);
        logic [2:0] last;
        case (op)
            OP_SCAN_IR: last = 3'(HDR_IR_LEN - 1);
            OP_SCAN_DR: last = 3'(HDR_DR_LEN - 1);
            default:    last = 3'(RST_SEQ_LEN - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK generator: DIV clocks low, DIV clocks high, starting with a fresh low
// phase the cycle enable rises. Strobes flag the CLK edge that will drop or
// raise TCK. hold_low keeps the pin low while the phase timing still runs.
module jtag_tck_gen #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_en,
    input  logic i_hold_low,
    output logic o_tck,
    output logic o_fall_stb,
    output logic o_rise_stb
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_tck;
    logic          w_tc;

    assign w_tc       = (r_cnt == '0);
    assign o_rise_stb = i_en && w_tc && !r_phase;
    assign o_fall_stb = i_en && w_tc && r_phase;
    assign o_tck      = r_tck;

    // Half-period down-counter; phase flips and reloads at terminal count
    always_ff @(posedge CLK) begin
        if (RST || !i_en) begin
            r_cnt   <= CNT_LOAD;
            r_phase <= 1'b0;
            r_tck   <= 1'b0;
        end else if (w_tc) begin
            r_cnt   <= CNT_LOAD;
            r_phase <= !r_phase;
            r_tck   <= !r_phase && !i_hold_low;
        end else begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG host controller: runs one TAP reset, IR scan, DR scan or idle-clock
// command at a time, always starting and ending in Run-Test/Idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no command; TCK low, TMS/TDI parked
// ST_TRST  | TRST_b low for one TCK period, TCK held low
// ST_HDR   | TMS lead-in walk (DR, IR or the 6-clock reset walk)
// ST_SHIFT | data bits (or idle clocks); TDO captured on each rise
// ST_TRL   | TMS trailer back to Run-Test/Idle
// ST_FIN   | one-cycle done pulse; a new command may be accepted here
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int DIV     = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic [$clog2(MAX_LEN+1)-1:0] len,
    input  logic [MAX_LEN-1:0]           din,
    output logic [MAX_LEN-1:0]           dout,
    output logic                         busy,
    output logic                         done,
    output logic                         TCK,
    output logic                         TMS,
    output logic                         TDI,
    input  logic                         TDO,
    output logic                         TRST_b
);

    localparam int            LW      = $clog2(MAX_LEN + 1);
    localparam int            IW      = (LW > 3) ? LW : 3;
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [1:0]         r_op;
    logic [LW-1:0]      r_len;
    logic [MAX_LEN-1:0] r_din;
    logic [MAX_LEN-1:0] r_dout;
    logic               r_tms;
    logic               r_tdi;
    logic               r_trst_b;

    logic               w_busy;
    logic               w_accept;
    logic               w_is_scan;
    logic               w_tck_en;
    logic               w_hold_low;
    logic               w_fall;
    logic               w_rise;
    logic [LW-1:0]      w_len_clamp;
    state_t             w_nxt_state;
    logic [IW-1:0]      w_nxt_idx;
    state_t             w_tgt_state;
    logic [IW-1:0]      w_tgt_idx;
    logic [1:0]         w_tgt_op;
    logic [LW-1:0]      w_tgt_len;
    logic [MAX_LEN-1:0] w_tgt_din;
    logic               w_din_bit;
    logic               w_tgt_tms;
    logic               w_tgt_tdi;

    assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign w_accept    = start && !w_busy;
    assign w_len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
    assign w_is_scan   = (r_op == OP_SCAN_IR) || (r_op == OP_SCAN_DR);
    // A zero-length shift spends its single busy cycle with TCK stopped
    assign w_tck_en    = (r_state == ST_TRST) || (r_state == ST_HDR) || (r_state == ST_TRL) ||
                         ((r_state == ST_SHIFT) && (r_len != '0));
    assign w_hold_low  = (r_state == ST_TRST);

    assign dout   = r_dout;
    assign busy   = w_busy;
    assign done   = (r_state == ST_FIN);
    assign TMS    = r_tms;
    assign TDI    = r_tdi;
    assign TRST_b = r_trst_b;

    jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (w_tck_en),
        .i_hold_low (w_hold_low),
        .o_tck      (TCK),
        .o_fall_stb (w_fall),
        .o_rise_stb (w_rise)
    );

    // Which TCK period follows the one that is ending
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx + IW'(1);
        case (r_state)
            ST_TRST: begin
                w_nxt_state = ST_HDR;
                w_nxt_idx   = '0;
            end
            ST_HDR: begin
                if (r_idx[2:0] == hdr_last(r_op)) begin
                    w_nxt_state = (r_op == OP_TAP_RESET) ? ST_FIN : ST_SHIFT;
                    w_nxt_idx   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_idx == IW'(r_len) - IW'(1)) begin
                    w_nxt_state = (r_op == OP_RUN_IDLE) ? ST_FIN : ST_TRL;
                    w_nxt_idx   = '0;
                end
            end
            ST_TRL: begin
                if (r_idx == IW'(TRL_LEN - 1)) begin
                    w_nxt_state = ST_FIN;
                    w_nxt_idx   = '0;
                end
            end
            default: ;
        endcase
    end

    // Acceptance is itself the start of the first low phase, so it uses the
    // raw inputs; otherwise the latched command steps to the next period
    always_comb begin
        if (w_accept) begin
            w_tgt_op  = op;
            w_tgt_len = w_len_clamp;
            w_tgt_din = din;
            w_tgt_idx = '0;
            case (op)
                OP_TAP_RESET: w_tgt_state = ST_TRST;
                OP_RUN_IDLE:  w_tgt_state = ST_SHIFT;
                default:      w_tgt_state = (w_len_clamp == '0) ? ST_SHIFT : ST_HDR;
            endcase
        end else begin
            w_tgt_op    = r_op;
            w_tgt_len   = r_len;
            w_tgt_din   = r_din;
            w_tgt_idx   = w_nxt_idx;
            w_tgt_state = w_nxt_state;
        end
    end

    // TMS/TDI levels presented for the coming TCK period
    always_comb begin
        w_din_bit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (IW'(k) == w_tgt_idx) w_din_bit = w_tgt_din[k];
        end
        w_tgt_tms = 1'b0;
        w_tgt_tdi = 1'b0;
        case (w_tgt_state)
            ST_TRST: w_tgt_tms = 1'b1;
            ST_HDR:  w_tgt_tms = hdr_bit(w_tgt_op, w_tgt_idx[2:0]);
            ST_SHIFT: begin
                if ((w_tgt_op != OP_RUN_IDLE) && (w_tgt_len != '0)) begin
                    w_tgt_tms = (w_tgt_idx == IW'(w_tgt_len) - IW'(1));
                    w_tgt_tdi = w_din_bit;
                end
            end
            ST_TRL:  w_tgt_tms = TRL[w_tgt_idx[0]];
            default: w_tgt_tms = r_tms;
        endcase
    end

    // Command sequencing, pin updates on TCK falls and TDO capture on rises
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_op     <= OP_TAP_RESET;
            r_len    <= '0;
            r_din    <= '0;
            r_dout   <= '0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_trst_b <= 1'b0;
        end else if (w_accept) begin
            r_state  <= w_tgt_state;
            r_idx    <= '0;
            r_op     <= op;
            r_len    <= w_len_clamp;
            r_din    <= din;
            r_dout   <= '0;
            r_tms    <= w_tgt_tms;
            r_tdi    <= w_tgt_tdi;
            r_trst_b <= (op != OP_TAP_RESET);
        end else begin
            r_trst_b <= !((r_state == ST_TRST) && !w_fall);
            case (r_state)
                ST_FIN: r_state <= ST_IDLE;
                ST_TRST, ST_HDR, ST_SHIFT, ST_TRL: begin
                    if ((r_state == ST_SHIFT) && (r_len == '0)) begin
                        r_state <= ST_FIN;
                        r_tdi   <= 1'b0;
                    end else begin
                        if (w_rise && (r_state == ST_SHIFT) && w_is_scan) begin
                            for (int k = 0; k < MAX_LEN; k++) begin
                                if (IW'(k) == r_idx) r_dout[k] <= TDO;
                            end
                        end
                        if (w_fall) begin
                            r_state <= w_tgt_state;
                            r_idx   <= w_tgt_idx;
                            r_tms   <= w_tgt_tms;
                            r_tdi   <= w_tgt_tdi;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: directed and random commands, each paired with an
// expected pin-level record from a reference model; monitors observe TCK
// rises and the done pulse and compare against the queued expectations.
module tb_jtag_host;

    localparam int MAX_LEN = 16;
    localparam int DIV     = 2;
    localparam int HP      = 2 * DIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [4:0]  len = 5'd0;
    logic [15:0] din = 16'h0;
    logic [15:0] dout;
    logic        busy, done, TCK, TMS, TDI, TDO, TRST_b;
    int          tdo_mode = 0;

    // 0: loopback, 1: tied high, 2: inverted loopback
    assign TDO = (tdo_mode == 0) ? TDI : (tdo_mode == 1) ? 1'b1 : ~TDI;

    always #5 CLK = ~CLK;

    jtag_host #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .len(len), .din(din),
        .dout(dout), .busy(busy), .done(done), .TCK(TCK), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TRST_b(TRST_b)
    );

    typedef struct {
        int          rises;
        logic [31:0] tms;
        logic [31:0] tdi;
        int          busy_cyc;
        int          trst_cyc;
        bit          chk_dout;
        logic [15:0] dout;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          obs_rises = 0;
    int          obs_busy = 0;
    int          obs_trst = 0;
    logic [31:0] obs_tms = '0;
    logic [31:0] obs_tdi = '0;
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Pin-level expectation built from the TAP walks described for each op
    function automatic exp_t model(input logic [1:0] op_i, input int len_i,
                                   input logic [15:0] din_i, input int mode);
        exp_t        e;
        int          n;
        int          p;
        logic [15:0] mask;
        n = (len_i > MAX_LEN) ? MAX_LEN : len_i;
        p = 0;
        mask = '0;
        e.tms = '0;
        e.tdi = '0;
        e.trst_cyc = 0;
        e.chk_dout = 1'b0;
        e.dout = '0;
        for (int i = 0; i < n; i++) mask[i] = 1'b1;
        case (op_i)
            2'b00: begin
                for (int i = 0; i < 5; i++) begin e.tms[p] = 1'b1; p++; end
                e.tms[p] = 1'b0; p++;
                e.trst_cyc = HP;
            end
            2'b01, 2'b10: begin
                e.chk_dout = 1'b1;
                if (n > 0) begin
                    e.tms[p] = 1'b1; p++;
                    if (op_i == 2'b01) begin e.tms[p] = 1'b1; p++; end
                    e.tms[p] = 1'b0; p++;
                    e.tms[p] = 1'b0; p++;
                    for (int i = 0; i < n; i++) begin
                        e.tms[p] = (i == n - 1);
                        e.tdi[p] = din_i[i];
                        p++;
                    end
                    e.tms[p] = 1'b1; p++;
                    e.tms[p] = 1'b0; p++;
                    case (mode)
                        0:       e.dout = din_i & mask;
                        1:       e.dout = mask;
                        default: e.dout = ~din_i & mask;
                    endcase
                end
            end
            default: p = n;
        endcase
        e.rises = p;
        e.busy_cyc = p * HP + e.trst_cyc;
        if (e.busy_cyc == 0) e.busy_cyc = 1;
        return e;
    endfunction

    // Record TMS/TDI as the target sees them on every TCK rise
    always @(posedge TCK) begin
        if (obs_rises < 32) begin
            obs_tms[obs_rises] = TMS;
            obs_tdi[obs_rises] = TDI;
        end
        obs_rises++;
    end

    // Count busy/TRST cycles and score each completed command
    always @(negedge CLK) begin
        exp_t        e;
        logic [31:0] m;
        if (busy) obs_busy++;
        if (busy && !TRST_b) obs_trst++;
        if (done) begin
            chk("done_width", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL done_unexpected: got a done pulse, expected no command pending");
            end else begin
                e = exp_q.pop_front();
                m = (e.rises >= 32) ? '1 : ((32'd1 << e.rises) - 32'd1);
                chk("tck_rises", obs_rises, e.rises);
                chk("tms_seq", obs_tms & m, e.tms);
                chk("tdi_seq", obs_tdi & m, e.tdi);
                chk("busy_cycles", obs_busy, e.busy_cyc);
                chk("trst_cycles", obs_trst, e.trst_cyc);
                if (e.chk_dout) chk("dout", {16'h0, dout}, {16'h0, e.dout});
            end
            obs_rises = 0; obs_busy = 0; obs_trst = 0; obs_tms = '0; obs_tdi = '0;
        end
        prev_done = done;
    end

    task automatic issue(input logic [1:0] o, input int l, input logic [15:0] d, input int md);
        tdo_mode = md;
        op = o;
        len = 5'(l);
        din = d;
        start = 1'b1;
        exp_q.push_back(model(o, l, d, md));
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 1000) begin
            n_total++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles", busy, exp_q.size(), k);
            exp_q.delete();
        end
        chk("idle_tck", {31'b0, TCK}, 32'd0);
        chk("idle_tdi", {31'b0, TDI}, 32'd0);
        chk("idle_trst_b", {31'b0, TRST_b}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tck", {31'b0, TCK}, 32'd0);
        chk("rst_tms", {31'b0, TMS}, 32'd1);
        chk("rst_tdi", {31'b0, TDI}, 32'd0);
        chk("rst_trst_b", {31'b0, TRST_b}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dout", {16'h0, dout}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("trst_b_release", {31'b0, TRST_b}, 32'd1);

        issue(2'b00, 0, 16'h0, 0);       wait_idle();
        issue(2'b10, 8, 16'h00A5, 0);    wait_idle();
        issue(2'b01, 2, 16'h0002, 1);    wait_idle();

        // second start while busy must be ignored
        issue(2'b10, 8, 16'h003C, 2);
        repeat (10) @(negedge CLK);
        op = 2'b11; len = 5'd3; din = 16'hFFFF; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_idle();
        issue(2'b10, 0, 16'hBEEF, 0);    wait_idle();

        // over-length request clamps to MAX_LEN
        issue(2'b10, 20, 16'hFFFF, 0);   wait_idle();

        // reset on the third shift pulse of a DR scan
        issue(2'b10, 8, 16'h00A5, 0);
        k = 0;
        while (obs_rises < 6 && k < 200) begin @(negedge CLK); k++; end
        if (k >= 200) begin
            n_total++;
            $display("FAIL shift_wait_timeout: rises=%0d, needed 6", obs_rises);
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_tck", {31'b0, TCK}, 32'd0);
        chk("mid_rst_tms", {31'b0, TMS}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_trst_b", {31'b0, TRST_b}, 32'd0);
        chk("mid_rst_dout", {16'h0, dout}, 32'd0);
        exp_q.delete();
        obs_rises = 0; obs_busy = 0; obs_trst = 0; obs_tms = '0; obs_tdi = '0;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_release", {31'b0, TRST_b}, 32'd1);
        issue(2'b00, 0, 16'h0, 0);       wait_idle();

        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                  16'($urandom), int'($urandom_range(0, 2)));
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
